obi_host_arbiter: RTL and testbench
===================================

# obi_host_arbiter

Two-port OBI arbiter that shares the single host OBI port between the L2 shared cache bus adapter (port 0) and a secondary requester (port 1, e.g. a host-side DMA or debug master). It applies round-robin arbitration to address phases and holds the chosen port until it is granted. It records the owner of every accepted transaction in an in-order ID FIFO and routes each response back to the port that issued it. It sits between the bus adapter's host interface and the top-level host OBI port.

## Interface
- MAX_OUTST, 4: maximum accepted-but-unresponded transactions; ID FIFO depth, power of two, ≥2.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- s0_req  obi_req_if.slave  intf  requester 0 address phase (L2 bus adapter).
- s0_rsp  obi_rsp_if.master  intf  requester 0 response.
- s1_req  obi_req_if.slave  intf  requester 1 address phase.
- s1_rsp  obi_rsp_if.master  intf  requester 1 response.
- m_req  obi_req_if.master  intf  host address phase.
- m_rsp  obi_rsp_if.slave  intf  host response.
- err_o  out  1  sticky protocol error (rvalid with empty FIFO); cleared only by reset.

## Operation
- State: `lock_q` (address phase owned), `owner_q` (locked port), `prio_q` (port with priority next), ID FIFO (MAX_OUTST × 1 bit, rd/wr pointers plus count), and `err_q`.
- Arbitration when `lock_q`=0:
  - If exactly one port requests, it wins.
  - If both request, `prio_q` wins.
  - The winner's addr/we/be/wdata drive m_req, and m_req.req=1.
- Lock: if the winner is not granted in the same cycle, set `lock_q`=1 and `owner_q`=winner. While locked, only `owner_q` is forwarded; the other port's req is ignored. OBI requires req and the address phase to be held stable until gnt.
- Accept: when m_req.req & m_req.gnt:
  - push the owner into the FIFO;
  - return gnt to the owner only (the non-owner sees gnt=0);
  - clear `lock_q`;
  - set `prio_q` = the port that was not granted.
- FIFO full: m_req.req is forced to 0 and no gnt reaches either requester. A simultaneous m_rsp.rvalid does not unblock that same cycle (1-cycle bubble).
- Response: when m_rsp.rvalid:
  - pop the FIFO head;
  - drive sN_rsp.rvalid=1 and rdata=m_rsp.rdata to head port N;
  - the other port sees rvalid=0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- rvalid with an empty FIFO: the response is dropped, no requester rvalid, and `err_q` is set to 1.
- Pointers are log2(MAX_OUTST) bits and wrap modulo MAX_OUTST. Count is log2(MAX_OUTST)+1 bits.

## Timing
- Zero-cycle request path: sN_req → m_req is combinational; m_req.gnt → sN_req.gnt is combinational.
- Response path is combinational: m_rsp → sN_rsp, selected by the registered FIFO head.
- Earliest response: rvalid arrives no earlier than the cycle after its gnt (OBI). A same-cycle push to an empty FIFO is not visible to that cycle's rvalid.
- Reset values:
  - FIFO empty, `lock_q`=0, `owner_q`=0, `prio_q`=0, err_o=0.
  - m_req.req=0; all sN gnt/rvalid=0.
- Reset mid-transaction: all state is cleared immediately. Outstanding host responses arriving after reset hit the empty FIFO and set err_o. System reset must cover the host side as well.
- Throughput: one accepted transaction per cycle while the FIFO is not full.

## Configuration
- OBI_HOST_ARB_PERF_EN
- Defined: adds three 32-bit outputs:
  - `perf_gnt0_o`: accepts for port 0;
  - `perf_gnt1_o`: accepts for port 1;
  - `perf_full_o`: cycles in which the FIFO was full with any sN_req.req=1.
  - All counters reset to 0 and wrap at 2^32.
- Not defined: these ports and counters are absent; behavior is otherwise identical.

## Test plan
- Both ports request continuously, host gnt=1, rvalid one cycle after each gnt → grants alternate 0,1,0,1; each rvalid is routed to the matching port with its rdata.
- Port 0 requests and host holds gnt=0 for 3 cycles while port 1 also requests → m_req keeps port 0's address stable all 3 cycles; port 1 is granted next after port 0's gnt.
- MAX_OUTST=4, 4 accepts with no rvalid → the 5th request sees m_req.req=0 until the cycle after the first rvalid; the 5th gnt occurs no earlier than that cycle.
- Interleaved accepts (ports 1,0,1) with responses rdata=0xA,0xB,0xC → s1 gets 0xA, s0 gets 0xB, s1 gets 0xC, in order.
- Inject rvalid with an empty FIFO → no sN rvalid, err_o=1 and sticky; assert rst_i → err_o=0.
- With OBI_HOST_ARB_PERF_EN: 5 accepts on port 0, 3 on port 1, 2 full-stall cycles → perf_gnt0_o=5, perf_gnt1_o=3, perf_full_o=2.

Source files
------------

// File: rtl/obi_host_arbiter_if.sv
// OBI address-phase and response-phase interfaces shared by the host arbiter and its requesters.
interface obi_req_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  modport master (output req, addr, we, be, wdata, input gnt);
  modport slave  (input req, addr, we, be, wdata, output gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output rvalid, rdata);
  modport slave  (input rvalid, rdata);
endinterface

// File: rtl/obi_host_arbiter.sv
// Two-port round-robin OBI arbiter with an in-order owner FIFO for response routing.
// Define OBI_HOST_ARB_PERF_EN to add grant/full-stall performance counters.
module obi_host_arbiter #(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  obi_req_if.slave   s0_req,
  obi_rsp_if.master  s0_rsp,
  obi_req_if.slave   s1_req,
  obi_rsp_if.master  s1_rsp,
  obi_req_if.master  m_req,
  obi_rsp_if.slave   m_rsp,
  output logic       err_o
`ifdef OBI_HOST_ARB_PERF_EN
  ,
  output logic [31:0] perf_gnt0_o,
  output logic [31:0] perf_gnt1_o,
  output logic [31:0] perf_full_o
`endif
);

  localparam int unsigned PtrW = $clog2(MAX_OUTST);

  logic                 lock_q, lock_d;
  logic                 owner_q, owner_d;
  logic                 prio_q, prio_d;
  logic                 err_q, err_d;
  logic [MAX_OUTST-1:0] fifo_q;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]        cnt_q, cnt_d;

  logic sel, win_req, fifo_full, fifo_empty, accept, pop, head;

  assign fifo_full  = (cnt_q == (PtrW+1)'(MAX_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // While locked the owner is held regardless of the other port's request.
  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = owner_q;
    end else if (s0_req.req && !s1_req.req) begin
      sel = 1'b0;
    end else if (s1_req.req && !s0_req.req) begin
      sel = 1'b1;
    end
    win_req = sel ? s1_req.req : s0_req.req;
  end

  assign accept = win_req & ~fifo_full & m_req.gnt;
  assign pop    = m_rsp.rvalid & ~fifo_empty;

  always_comb begin
    m_req.req     = win_req & ~fifo_full;
    m_req.addr    = sel ? s1_req.addr  : s0_req.addr;
    m_req.we      = sel ? s1_req.we    : s0_req.we;
    m_req.be      = sel ? s1_req.be    : s0_req.be;
    m_req.wdata   = sel ? s1_req.wdata : s0_req.wdata;
    s0_req.gnt    = accept & ~sel;
    s1_req.gnt    = accept & sel;
    s0_rsp.rvalid = pop & ~head;
    s1_rsp.rvalid = pop & head;
    s0_rsp.rdata  = m_rsp.rdata;
    s1_rsp.rdata  = m_rsp.rdata;
    err_o         = err_q;
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    if (accept) begin
      lock_d = 1'b0;
      prio_d = ~sel;
    end else if (win_req && !fifo_full) begin
      lock_d  = 1'b1;
      owner_d = sel;
    end else begin
      // Keep the lock across a full stall; release it if the owner withdraws.
      lock_d = lock_q & win_req;
    end

    wr_ptr_d = wr_ptr_q + PtrW'(accept);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end

    err_d = err_q | (m_rsp.rvalid & fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      err_q    <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (accept) begin
        fifo_q[wr_ptr_q] <= sel;
      end
    end
  end

`ifdef OBI_HOST_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_gnt0_o <= '0;
      perf_gnt1_o <= '0;
      perf_full_o <= '0;
    end else begin
      if (accept && !sel) perf_gnt0_o <= perf_gnt0_o + 32'd1;
      if (accept && sel)  perf_gnt1_o <= perf_gnt1_o + 32'd1;
      if (fifo_full && (s0_req.req || s1_req.req)) perf_full_o <= perf_full_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obi_host_arbiter.sv
// Directed bench for obi_host_arbiter: stimulus pushes expected grants/responses, a monitor pops.
module tb_obi_host_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
`ifdef OBI_HOST_ARB_PERF_EN
  logic [31:0] perf_g0, perf_g1, perf_full;
`endif

  obi_req_if s0_req ();
  obi_req_if s1_req ();
  obi_req_if m_req ();
  obi_rsp_if s0_rsp ();
  obi_rsp_if s1_rsp ();
  obi_rsp_if m_rsp ();

  obi_host_arbiter #(.MAX_OUTST(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .s0_req (s0_req),
    .s0_rsp (s0_rsp),
    .s1_req (s1_req),
    .s1_rsp (s1_rsp),
    .m_req  (m_req),
    .m_rsp  (m_rsp),
    .err_o  (err)
`ifdef OBI_HOST_ARB_PERF_EN
    ,
    .perf_gnt0_o (perf_g0),
    .perf_gnt1_o (perf_g1),
    .perf_full_o (perf_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic exp_g(input logic p, input logic [31:0] a);
    gnt_q.push_back('{port: p, data: a});
  endtask

  task automatic exp_r(input logic p, input logic [31:0] d);
    rsp_q.push_back('{port: p, data: d});
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1,
                       input logic [31:0] a1, input logic g, input logic rv,
                       input logic [31:0] rd);
    s0_req.req   = r0;
    s0_req.addr  = a0;
    s0_req.we    = 1'b0;
    s0_req.be    = 4'hF;
    s0_req.wdata = ~a0;
    s1_req.req   = r1;
    s1_req.addr  = a1;
    s1_req.we    = 1'b1;
    s1_req.be    = 4'h3;
    s1_req.wdata = ~a1;
    m_req.gnt    = g;
    m_rsp.rvalid = rv;
    m_rsp.rdata  = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every grant and response the DUT presents must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (s0_req.gnt || s1_req.gnt) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", {30'b0, s1_req.gnt, s0_req.gnt}, 32'd0);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_port", {30'b0, s1_req.gnt, s0_req.gnt}, e.port ? 32'd2 : 32'd1);
          check("gnt_addr", m_req.addr, e.data);
        end
      end
      if (s0_rsp.rvalid || s1_rsp.rvalid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {30'b0, s1_rsp.rvalid, s0_rsp.rvalid}, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_port", {30'b0, s1_rsp.rvalid, s0_rsp.rvalid}, e.port ? 32'd2 : 32'd1);
          check("rsp_data", e.port ? s1_rsp.rdata : s0_rsp.rdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", m_req.req, 0);
    check("rst_gnt0", s0_req.gnt, 0);
    check("rst_gnt1", s1_req.gnt, 0);
    check("rst_rvalid", {s1_rsp.rvalid, s0_rsp.rvalid}, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Both ports request continuously; grants alternate, responses trail by one cycle.
    for (int c = 0; c < 7; c++) begin
      drive(1, 32'h1000_0000, 1, 32'h2000_0000, c < 6, c >= 1, 32'hD000 + c);
      if (c < 6) exp_g(c[0], c[0] ? 32'h2000_0000 : 32'h1000_0000);
      if (c >= 1) exp_r(~c[0], 32'hD000 + c);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // One port-0 accept moves priority to port 1, then lock must hold port 0 anyway.
    drive(1, 32'h1000_0100, 0, 0, 1, 0, 0);
    exp_g(0, 32'h1000_0100);
    tick();
    for (int b = 0; b < 3; b++) begin
      drive(1, 32'h0000_1111, b > 0, 32'h0000_2222, 0, 0, 0);
      @(negedge clk);
      check("lock_req", m_req.req, 1);
      check("lock_addr", m_req.addr, 32'h0000_1111);
      tick();
    end
    drive(1, 32'h0000_1111, 1, 32'h0000_2222, 1, 0, 0);
    exp_g(0, 32'h0000_1111);
    tick();
    drive(1, 32'h0000_3333, 1, 32'h0000_2222, 1, 0, 0);
    exp_g(1, 32'h0000_2222);
    tick();
    drive(1, 32'h0000_3333, 0, 0, 1, 1, 32'h51);
    exp_g(0, 32'h0000_3333);
    exp_r(0, 32'h51);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h52);
    exp_r(0, 32'h52);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h53);
    exp_r(1, 32'h53);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h54);
    exp_r(0, 32'h54);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Fill the FIFO, then verify the stall and the one-cycle bubble after the first response.
    for (int c = 0; c < 4; c++) begin
      drive(1, 32'h4000_0000, 0, 0, 1, 0, 0);
      exp_g(0, 32'h4000_0000);
      tick();
    end
    drive(1, 32'h4000_0000, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("full_req", m_req.req, 0);
    tick();
    drive(1, 32'h4000_0000, 0, 0, 1, 1, 32'h60);
    exp_r(0, 32'h60);
    @(negedge clk);
    check("full_bubble_req", m_req.req, 0);
    tick();
    drive(1, 32'h4000_0000, 0, 0, 1, 0, 0);
    exp_g(0, 32'h4000_0000);
    @(negedge clk);
    check("unblock_req", m_req.req, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'h61 + i);
      exp_r(0, 32'h61 + i);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Interleaved owners 1,0,1 must each receive their own response.
    drive(0, 0, 1, 32'h5000, 1, 0, 0);
    exp_g(1, 32'h5000);
    tick();
    drive(1, 32'h6000, 0, 0, 1, 0, 0);
    exp_g(0, 32'h6000);
    tick();
    drive(0, 0, 1, 32'h5004, 1, 0, 0);
    exp_g(1, 32'h5004);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hA);
    exp_r(1, 32'hA);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hB);
    exp_r(0, 32'hB);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hC);
    exp_r(1, 32'hC);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    check("gnt_q_drained", gnt_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
`ifdef OBI_HOST_ARB_PERF_EN
    check("perf_gnt0", perf_g0, 32'd12);
    check("perf_gnt1", perf_g1, 32'd6);
    check("perf_full", perf_full, 32'd2);
`endif

    // Response with nothing outstanding: dropped, error latched until reset.
    drive(0, 0, 0, 0, 0, 1, 32'hDEAD);
    @(negedge clk);
    check("orphan_rvalid", {s1_rsp.rvalid, s0_rsp.rvalid}, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("err_set", err, 1);
    tick();
    tick();
    @(negedge clk);
    check("err_sticky", err, 1);
    rst = 1'b1;
    #1;
    check("err_cleared", err, 0);
    check("rst2_m_req", m_req.req, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
